// File: rtl/return_stack_unit_if.sv
// return_stack_unit_if: groups the push/pop strobes and the stack status/result signals.
interface return_stack_unit_if #(
   parameter int ADDR_W = 12,
   parameter int PTR_W  = 3
);
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] pc_in;
   logic              clear_err;
   logic [ADDR_W-1:0] ret_addr;
   logic              ret_valid;
   logic [PTR_W:0]    count;
   logic              full;
   logic              empty;
   logic              overflow;
   logic              underflow;
   logic              err;
   modport master (
      output push, pop, pc_in, clear_err,
      input  ret_addr, ret_valid, count, full, empty, overflow, underflow, err
   );
   modport slave (
      input  push, pop, pc_in, clear_err,
      output ret_addr, ret_valid, count, full, empty, overflow, underflow, err
   );
endinterface

// File: rtl/return_stack_unit.sv
// return_stack_unit: call/return address stack with registered pop output and a sticky error state.
module return_stack_unit #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 8,
   parameter int PTR_W  = 3
) (
   input logic           clock,
   input logic           init_signal,
   return_stack_unit_if.slave bus
);
   typedef enum logic {RUN, ERROR} state_t;
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W:0]    cnt, cnt_nxt, cnt_m1;
   logic [ADDR_W-1:0] ra, ra_nxt;
   logic              rv, rv_nxt, ovf, ovf_nxt, udf, udf_nxt, wr_en, full, empty;
   logic [PTR_W-1:0]  wr_idx, top;
   assign cnt_m1 = cnt - (PTR_W+1)'(1);
   assign top    = cnt_m1[PTR_W-1:0];
   assign full   = cnt == (PTR_W+1)'(DEPTH);
   assign empty  = cnt == '0;
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ra_nxt    = ra;
      rv_nxt    = 1'b0;
      ovf_nxt   = ovf;
      udf_nxt   = udf;
      wr_en     = 1'b0;
      wr_idx    = cnt[PTR_W-1:0];
      if (state == ERROR) begin
         if (bus.clear_err) begin
            state_nxt = RUN;
            ovf_nxt   = 1'b0;
            udf_nxt   = 1'b0;
         end
      end else if (bus.push && bus.pop) begin
         wr_en = 1'b1;
         if (empty) begin
            // simultaneous push/pop on an empty stack degrades to a plain push
            wr_idx    = '0;
            cnt_nxt   = (PTR_W+1)'(1);
            udf_nxt   = 1'b1;
            state_nxt = ERROR;
         end else begin
            wr_idx = top;
            ra_nxt = mem[top];
            rv_nxt = 1'b1;
         end
      end else if (bus.push) begin
         wr_en     = !full;
         cnt_nxt   = full ? cnt : cnt + (PTR_W+1)'(1);
         ovf_nxt   = ovf | full;
         state_nxt = full ? ERROR : RUN;
      end else if (bus.pop) begin
         ra_nxt    = empty ? ra : mem[top];
         rv_nxt    = !empty;
         cnt_nxt   = empty ? cnt : cnt_m1;
         udf_nxt   = udf | empty;
         state_nxt = empty ? ERROR : RUN;
      end
   end
   always_ff @(posedge clock) begin
      if (init_signal) begin
         state <= RUN;
         cnt   <= '0;
         ra    <= '0;
         rv    <= 1'b0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ra    <= ra_nxt;
         rv    <= rv_nxt;
         ovf   <= ovf_nxt;
         udf   <= udf_nxt;
      end
   end
   always_ff @(posedge clock) begin
      if (wr_en && !init_signal) mem[wr_idx] <= bus.pc_in;
   end
   assign bus.ret_addr  = ra;
   assign bus.ret_valid = rv;
   assign bus.count     = cnt;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.overflow  = ovf;
   assign bus.underflow = udf;
   assign bus.err       = state == ERROR;
endmodule

// File: tb/tb_return_stack_unit.sv
// tb_return_stack_unit: directed test-plan steps plus random traffic, checked against a queue-based stack model.
module tb_return_stack_unit;
   localparam int ADDR_W = 12;
   localparam int DEPTH  = 8;
   localparam int PTR_W  = 3;
   logic clock = 1'b0;
   logic init_signal;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   q[$];
   int   m_ra;
   logic m_rv, m_ovf, m_udf, m_err;
   return_stack_unit_if #(.ADDR_W(ADDR_W), .PTR_W(PTR_W)) bus();
   return_stack_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clock(clock),
      .init_signal(init_signal),
      .bus(bus.slave)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model(input logic r, input logic p, input logic o, input int pc, input logic c);
      if (r) begin
         q.delete();
         {m_rv, m_ovf, m_udf, m_err} = '0;
         m_ra = 0;
      end else if (m_err) begin
         m_rv = 1'b0;
         if (c) {m_err, m_ovf, m_udf} = '0;
      end else begin
         m_rv = 1'b0;
         if (p && o) begin
            if (q.size() == 0) begin
               q.push_back(pc);
               m_udf = 1'b1;
               m_err = 1'b1;
            end else begin
               m_ra = q[$];
               m_rv = 1'b1;
               q[q.size()-1] = pc;
            end
         end else if (p) begin
            if (q.size() == DEPTH) begin
               m_ovf = 1'b1;
               m_err = 1'b1;
            end else q.push_back(pc);
         end else if (o) begin
            if (q.size() == 0) begin
               m_udf = 1'b1;
               m_err = 1'b1;
            end else begin
               m_ra = q.pop_back();
               m_rv = 1'b1;
            end
         end
      end
   endtask
   task automatic step(input logic r, input logic p, input logic o, input int pc, input logic c);
      init_signal   = r;
      bus.push      = p;
      bus.pop       = o;
      bus.pc_in     = pc[ADDR_W-1:0];
      bus.clear_err = c;
      @(posedge clock);
      #1;
      model(r, p, o, pc, c);
      chk("count", 32'(bus.count), 32'(q.size()));
      chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("ret_valid", 32'(bus.ret_valid), 32'(m_rv));
      chk("ret_addr", 32'(bus.ret_addr), 32'(m_ra));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_udf));
      chk("err", 32'(bus.err), 32'(m_err));
   endtask
   initial begin
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 'h101 + i, 0);
      chk("plan1_count3", 32'(bus.count), 3);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0, 0);
         chk("plan1_pop", 32'(bus.ret_addr), 'h103 - i);
      end
      chk("plan1_empty", 32'(bus.empty), 1);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 'h010 + i, 0);
      chk("plan2_full", 32'(bus.full), 1);
      step(0, 1, 0, 'h0FF, 0);
      chk("plan2_ovf", 32'({bus.overflow, bus.err, bus.count}), 32'({2'b11, 4'd8}));
      step(0, 0, 1, 0, 0);
      chk("plan2_frozen_rv", 32'(bus.ret_valid), 0);
      step(0, 0, 0, 0, 1);
      chk("plan2_clear", 32'({bus.err, bus.overflow}), 0);
      step(0, 0, 1, 0, 0);
      chk("plan2_pop", 32'(bus.ret_addr), 'h017);
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("plan3_udf", 32'({bus.underflow, bus.err, bus.ret_valid, bus.ret_addr}), 32'({3'b110, 12'h000}));
      step(0, 0, 0, 0, 1);
      step(0, 1, 0, 'h0AA, 0);
      step(0, 0, 1, 0, 0);
      chk("plan3_pop", 32'(bus.ret_addr), 'h0AA);
      step(0, 1, 0, 'h200, 0);
      step(0, 1, 0, 'h201, 0);
      step(0, 1, 1, 'h3FF, 0);
      chk("plan4_replace", 32'({bus.ret_addr, bus.count}), 32'({12'h201, 4'd2}));
      step(0, 0, 1, 0, 0);
      chk("plan4_pop", 32'(bus.ret_addr), 'h3FF);
      step(0, 1, 0, 'h050, 0);
      step(0, 1, 0, 'h051, 0);
      step(1, 0, 1, 0, 0);
      chk("plan5_reset", 32'({bus.count, bus.ret_valid, bus.overflow, bus.underflow, bus.err}), 0);
      step(0, 0, 1, 0, 0);
      chk("plan5_udf", 32'(bus.underflow), 1);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         step(0, i % 2 == 0, i % 2 == 1, 'h123, 0);
         if (i % 2 == 1) chk("plan6_pop", 32'(bus.ret_addr), 'h123);
      end
      chk("plan6_flags", 32'({bus.overflow, bus.underflow, bus.err}), 0);
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
              int'($urandom_range(0, 4095)), $urandom_range(0, 3) == 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/return_stack_unit.md
Name: return_stack_unit

Overview:
- Hardware call/return-address stack driven by the instruction controller's push and pop strobes (CALL = push, RET = pop).
- Saves the 12-bit return PC on push. Delivers the saved PC on pop through a registered output, for the PC-input mux select 2'b10 path.
- Tracks occupancy and flags overflow/underflow.
- Freezes in an error state on misuse until it is cleared.

Parameters:
- ADDR_W, 12, width of a stored return address (matches the instruction address field [11:0]).
- DEPTH, 8, number of stack entries; must be a power of two, at least 2.
- PTR_W, 3, log2(DEPTH); the stack pointer and count are PTR_W+1 bits.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- init_signal  input  1  synchronous active-high reset.
- push  input  1  write pc_in to top of stack this cycle.
- pop  input  1  remove top of stack this cycle.
- pc_in  input  ADDR_W  return address to save (already PC+1, supplied by datapath).
- clear_err  input  1  synchronous; leaves the ERROR state, keeps stack contents.
- ret_addr  output  ADDR_W  registered popped address.
- ret_valid  output  1  one-cycle pulse; ret_addr is new this cycle.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH (combinational from count).
- empty  output  1  count == 0 (combinational from count).
- overflow  output  1  sticky; push attempted while full.
- underflow  output  1  sticky; pop attempted while empty.
- err  output  1  high while the FSM is in ERROR.

Behaviour:
- Reset (init_signal=1 at an edge): FSM=RUN, count=0, ret_addr=0, ret_valid=0, overflow=0, underflow=0, err=0. Storage array is not cleared. init_signal has priority over every other input.
- Storage: DEPTH x ADDR_W registers. Entry k is valid for k < count. Top of stack = entry count-1.
- FSM states: RUN, ERROR.
- In RUN, per cycle, evaluate {push,pop}:
  - 00: no change; ret_valid=0 next cycle.
  - 10, not full: entry[count] <= pc_in; count+1.
  - 10, full: no write, count unchanged; overflow <= 1; next state ERROR.
  - 01, not empty: ret_addr <= entry[count-1]; ret_valid <= 1 next cycle; count-1. Entry contents are left in place.
  - 01, empty: ret_addr holds, ret_valid=0; underflow <= 1; next state ERROR.
  - 11, not empty: replace top. ret_addr <= old entry[count-1], ret_valid <= 1, entry[count-1] <= pc_in, count unchanged. Full is not an error in this case.
  - 11, empty: treated as push only (entry[0] <= pc_in, count=1); underflow <= 1; next state ERROR.
- ERROR state:
  - push/pop ignored; count and storage frozen; ret_valid=0; err=1.
  - clear_err=1 -> RUN next cycle; overflow and underflow cleared in the same edge; count and storage retained.
  - clear_err in RUN has no effect except clearing the sticky flags (which are already 0).
- Latency: push-to-count update is 1 cycle. pop to ret_addr/ret_valid is 1 cycle (registered).
- Back-to-back pops each deliver successive entries with no bubble. Pop in the cycle after push returns the just-pushed value.
- Arithmetic: count is unsigned PTR_W+1 bits. Index uses the low PTR_W bits. No wrap: count never exceeds DEPTH and never goes below 0.
- Outputs other than full/empty are registered; full/empty/err decode from registered state only, with no input-to-output combinational paths.

Test Plan:
- Reset, then push 0x101,0x102,0x103 on consecutive cycles, then pop 3x -> count 1,2,3 then 2,1,0; ret_addr 0x103,0x102,0x101 with ret_valid high each cycle after pop; empty=1 at end.
- Fill 8 entries (0x010..0x017) -> full=1, count=8. Push 0x0FF -> overflow=1, err=1, count stays 8. Further pop ignored (ret_valid=0). clear_err -> err=0, overflow=0. Pop -> ret_addr=0x017.
- From reset, pop -> underflow=1, err=1, ret_valid=0, ret_addr=0. clear_err then push 0x0AA, pop -> ret_addr=0x0AA.
- Push 0x200, 0x201. Assert push+pop with pc_in=0x3FF -> ret_addr=0x201, count=2. Pop -> ret_addr=0x3FF.
- Push 0x050,0x051. Assert init_signal while pop is asserted -> count=0, ret_valid=0, flags 0. Following pop -> underflow=1.
- Alternate push 0x123 / pop each cycle for 16 cycles -> count toggles 1/0, every pop returns 0x123, no flags set.
